// File: rtl/line_feeder.sv
// Two-row line buffer feeding vertical 3-pixel columns to the pixel unit.
// Tracks raster position and pulses frame_done with the final column.
module line_feeder #(
   parameter int XB    = 10,
   parameter int YB    = 10,
   parameter int PB    = 8,
   parameter int NM    = 4,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [PB-1:0] pix_in,
   input  logic          pix_in_valid,
   output logic          pix_in_ready,
   output logic [PB-1:0] col_data [NM],
   output logic          col_en,
   output logic [XB-1:0] col_x,
   output logic [YB-1:0] row_y,
   output logic          busy,
   output logic          frame_done
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM,
      DONE
   } state_t;

   state_t        state;
   logic [XB-1:0] x;
   logic [YB-1:0] y;
   logic [XB-1:0] nx;
   logic [YB-1:0] ny;
   logic [AW-1:0] xa;
   logic [PB-1:0] la [IMG_W];
   logic [PB-1:0] lb [IMG_W];
   logic [PB-1:0] la_q;
   logic [PB-1:0] lb_q;
   logic          acc;
   logic          x_last;
   logic          y_last;

   assign acc    = pix_in_valid & pix_in_ready;
   assign x_last = (x == XB'(IMG_W - 1));
   assign y_last = (y == YB'(IMG_H - 1));
   assign xa     = x[AW-1:0];
   assign la_q   = la[xa];
   assign lb_q   = lb[xa];
   assign nx     = x_last ? '0 : x + 1'b1;
   assign ny     = x_last ? y + 1'b1 : y;

   // Old row contents are read in the same cycle they are shifted down.
   always_ff @(posedge clk) begin
      if (acc && rst) begin
         lb[xa] <= la_q;
         la[xa] <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         x            <= '0;
         y            <= '0;
         pix_in_ready <= 1'b0;
         busy         <= 1'b0;
         col_en       <= 1'b0;
         frame_done   <= 1'b0;
         col_x        <= '0;
         row_y        <= '0;
         for (int i = 0; i < NM; i++) col_data[i] <= '0;
      end else begin
         col_en     <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 3; i < NM; i++) col_data[i] <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state        <= FILL;
                  x            <= '0;
                  y            <= '0;
                  pix_in_ready <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            FILL: begin
               if (acc) begin
                  x <= nx;
                  y <= ny;
                  if (x_last && y == YB'(1)) state <= STREAM;
               end
            end
            STREAM: begin
               if (acc) begin
                  col_en      <= 1'b1;
                  col_data[0] <= lb_q;
                  col_data[1] <= la_q;
                  col_data[2] <= pix_in;
                  col_x       <= x;
                  row_y       <= y;
                  x           <= nx;
                  y           <= ny;
                  if (x_last && y_last) begin
                     state        <= DONE;
                     pix_in_ready <= 1'b0;
                     busy         <= 1'b0;
                     frame_done   <= 1'b1;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_feeder.sv
// Randomised bench for line_feeder against a frame-array column model.
// Expected columns come straight from the stored image rows.
module tb_line_feeder;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] pix_in;
   logic       pix_in_valid;
   logic       pix_in_ready;
   logic [7:0] col_data [4];
   logic       col_en;
   logic [9:0] col_x;
   logic [9:0] row_y;
   logic       busy;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   logic [7:0] held_d [3];
   int         held_x;
   int         held_y;

   line_feeder #(
      .XB(10), .YB(10), .PB(8), .NM(4), .IMG_W(W), .IMG_H(H)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .pix_in(pix_in),
      .pix_in_valid(pix_in_valid),
      .pix_in_ready(pix_in_ready),
      .col_data(col_data),
      .col_en(col_en),
      .col_x(col_x),
      .row_y(row_y),
      .busy(busy),
      .frame_done(frame_done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic clear_held();
      for (int i = 0; i < 3; i++) held_d[i] = 8'h00;
      held_x = 0;
      held_y = 0;
   endtask

   // pmode: 0 = 16y+x, 1 = 0x80+16y+x, 2 = random
   // vmode: 0 = valid held, 1 = toggling, 2 = random
   task automatic run_frame(input int pmode, input int vmode,
                            input int abort_n, input bit rand_start);
      logic [7:0] img [H][W];
      int n, k, dut_cols, px, py;
      logic v, e_en, e_done, e_rdy;
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            img[yy][xx] = (pmode == 0) ? 8'(16 * yy + xx) :
                          (pmode == 1) ? 8'(8'h80 + 16 * yy + xx) :
                          8'($urandom);
      start = 1;
      pix_in_valid = 1'($urandom % 2);
      pix_in = 8'($urandom);
      @(negedge clk);
      start = 0;
      total++;
      if ({col_en, frame_done, pix_in_ready, busy} !== 4'b0011) begin
         bad++;
         $display("FAIL start_state got=%b want=0011",
                  {col_en, frame_done, pix_in_ready, busy});
      end
      n = 0;
      k = 0;
      dut_cols = 0;
      while (n < W * H && k < 1000) begin
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(k % 2 == 0) :
             1'($urandom % 2);
         k++;
         pix_in_valid = v;
         pix_in = img[n / W][n % W];
         start = rand_start ? 1'($urandom % 2) : 1'b0;
         @(negedge clk);
         e_en = 0;
         e_done = 0;
         if (v) begin
            px = n % W;
            py = n / W;
            if (py >= 2) begin
               e_en = 1;
               held_d[0] = img[py-2][px];
               held_d[1] = img[py-1][px];
               held_d[2] = img[py][px];
               held_x = px;
               held_y = py;
               e_done = (n == W * H - 1);
            end
            n++;
         end
         e_rdy = (n < W * H);
         dut_cols += int'(col_en);
         total++;
         if ({col_en, frame_done, pix_in_ready, busy} !==
             {e_en, e_done, e_rdy, e_rdy}) begin
            bad++;
            $display("FAIL ctl n=%0d got=%b want=%b", n,
                     {col_en, frame_done, pix_in_ready, busy},
                     {e_en, e_done, e_rdy, e_rdy});
         end
         total++;
         if (col_data[0] !== held_d[0] || col_data[1] !== held_d[1] ||
             col_data[2] !== held_d[2] || col_data[3] !== 8'h00 ||
             col_x !== 10'(held_x) || row_y !== 10'(held_y)) begin
            bad++;
            $display("FAIL col n=%0d got=%h %h %h %h x=%0d y=%0d want=%h %h %h 00 x=%0d y=%0d",
                     n, col_data[0], col_data[1], col_data[2], col_data[3],
                     col_x, row_y, held_d[0], held_d[1], held_d[2],
                     held_x, held_y);
         end
         if (n == abort_n) begin
            rst = 0;
            pix_in_valid = 1'($urandom % 2);
            pix_in = 8'($urandom);
            start = 1'($urandom % 2);
            @(negedge clk);
            rst = 1;
            start = 0;
            pix_in_valid = 0;
            clear_held();
            total++;
            if ({col_en, frame_done, pix_in_ready, busy} !== 4'b0000 ||
                col_x !== 10'd0 || row_y !== 10'd0 ||
                {col_data[0], col_data[1], col_data[2], col_data[3]} !== 32'h0) begin
               bad++;
               $display("FAIL abort_reset ctl=%b x=%0d y=%0d d=%h %h %h %h want=0",
                        {col_en, frame_done, pix_in_ready, busy}, col_x, row_y,
                        col_data[0], col_data[1], col_data[2], col_data[3]);
            end
            return;
         end
      end
      if (k >= 1000) begin
         total++;
         bad++;
         $display("FAIL frame_timeout accepted=%0d want=%0d", n, W * H);
      end
      pix_in_valid = 0;
      start = 0;
      @(negedge clk);
      total++;
      if ({col_en, frame_done, pix_in_ready, busy} !== 4'b0000 ||
          col_data[2] !== held_d[2] || col_x !== 10'(held_x)) begin
         bad++;
         $display("FAIL post_frame ctl=%b d2=%h x=%0d want=0000 d2=%h x=%0d",
                  {col_en, frame_done, pix_in_ready, busy}, col_data[2],
                  col_x, held_d[2], held_x);
      end
      total++;
      if (dut_cols != W * (H - 2)) begin
         bad++;
         $display("FAIL col_count got=%0d want=%0d", dut_cols, W * (H - 2));
      end
   endtask

   task automatic test_reset();
      rst = 0;
      for (int c = 0; c < 2; c++) begin
         start = 1'($urandom % 2);
         pix_in_valid = 1'($urandom % 2);
         pix_in = 8'($urandom);
         @(negedge clk);
         total++;
         if ({col_en, frame_done, pix_in_ready, busy} !== 4'b0000 ||
             col_x !== 10'd0 || row_y !== 10'd0 ||
             {col_data[0], col_data[1], col_data[2], col_data[3]} !== 32'h0) begin
            bad++;
            $display("FAIL reset ctl=%b x=%0d y=%0d d=%h %h %h %h want=0",
                     {col_en, frame_done, pix_in_ready, busy}, col_x, row_y,
                     col_data[0], col_data[1], col_data[2], col_data[3]);
         end
      end
      rst = 1;
      start = 0;
      pix_in_valid = 0;
      clear_held();
      @(negedge clk);
      total++;
      if ({pix_in_ready, busy} !== 2'b00) begin
         bad++;
         $display("FAIL reset_idle got=%b want=00", {pix_in_ready, busy});
      end
   endtask

   task automatic test_full_frame();
      run_frame(0, 0, -1, 1'b0);
   endtask

   task automatic test_bubbles();
      run_frame(0, 1, -1, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      start = 0;
      for (int c = 0; c < 3; c++) begin
         pix_in_valid = 1;
         pix_in = 8'($urandom);
         @(negedge clk);
         total++;
         if ({col_en, pix_in_ready, busy} !== 3'b000) begin
            bad++;
            $display("FAIL idle_valid got=%b want=000",
                     {col_en, pix_in_ready, busy});
         end
      end
      run_frame(2, 2, -1, 1'b1);
      run_frame(0, 0, -1, 1'b1);
   endtask

   task automatic test_reset_mid();
      run_frame(0, 0, 2 * W + 2, 1'b0);
      run_frame(1, 0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_frame(0, 0, -1, 1'b0);
      run_frame(0, 0, -1, 1'b0);
      run_frame(2, 2, -1, 1'b0);
   endtask

   initial begin
      rst = 0;
      start = 0;
      pix_in = 0;
      pix_in_valid = 0;
      clear_held();
      @(negedge clk);
      test_reset();
      test_full_frame();
      test_bubbles();
      test_ignored_inputs();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
